seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 119 +++++++++++
 tb/tb_seg7_scan_driver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with a per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] out_0,
  input  logic [3:0] out_1,
  input  logic [3:0] out_2,
  input  logic [3:0] out_3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam logic [DIV_W-1:0] LP_PRESC_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [3:0][3:0]  r_shadow;
  logic             r_load_pending;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_frame_tick;

  logic             w_tick;
  logic             w_load;
  logic [3:0]       w_blank;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      4'hF:    hex_to_seg = 7'b0001110;
      default: hex_to_seg = 7'b1111111;
    endcase
  endfunction

  // Scan timing: digit advance and frame snapshot strobe
  always_comb begin
    w_tick = (r_presc == LP_PRESC_LAST);
    w_load = r_load_pending | (w_tick & (r_idx == 2'd3));
  end

  // Leading-zero blank mask, derived from the snapshot only
  always_comb begin
    w_blank = 4'b0000;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    w_blank[3] = (r_shadow[3] == 4'h0);
    w_blank[2] = w_blank[3] & (r_shadow[2] == 4'h0);
    w_blank[1] = w_blank[2] & (r_shadow[1] == 4'h0);
    w_blank[0] = 1'b0;
`endif
  end

  // Segment pattern for the digit currently selected
  always_comb begin
    w_digit    = r_shadow[r_idx];
    w_seg_next = w_blank[r_idx] ? 7'b1111111 : hex_to_seg(w_digit);
  end

  // Prescaler, digit index, snapshot and registered display outputs.
  // The prescaler holds through the initial load cycle so every digit,
  // including the first one after reset, is lit for a full REFRESH_DIV.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc        <= '0;
      r_idx          <= 2'd0;
      r_shadow       <= '0;
      r_load_pending <= 1'b1;
      r_an           <= 4'b1111;
      r_seg          <= 7'b1111111;
      r_frame_tick   <= 1'b0;
    end else begin
      r_load_pending <= 1'b0;
      r_frame_tick   <= w_load;
      if (r_load_pending || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + DIV_W'(1);
      end
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_load) begin
        r_shadow <= {out_3, out_2, out_1, out_0};
      end
      if (r_load_pending) begin
        r_an  <= 4'b1111;
        r_seg <= 7'b1111111;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_seg_next;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (REFRESH_DIV=4 and 2) share
// stimulus; expected an/seg/frame_tick come from a cycle-indexed scan model.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] out_0, out_1, out_2, out_3;
  logic [3:0] an4, an2;
  logic [6:0] seg4, seg2;
  logic       ft4, ft2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] in_hist [0:511];
  logic [6:0]  dec_tab [16];
  logic [3:0]  an_tab  [4];

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4), .DIV_W(3)) u_dut4 (
    .clk(clk), .reset(reset),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .an(an4), .seg(seg4), .frame_tick(ft4)
  );

  seg7_scan_driver #(.REFRESH_DIV(2), .DIV_W(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .an(an2), .seg(seg2), .frame_tick(ft2)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Input pattern {out_3,out_2,out_1,out_0} driven during cycle n of a phase
  function automatic logic [15:0] stim(input int mode, input int n);
    logic [3:0] b;
    b = 4'(n >> 4);
    case (mode)
      0:       stim = (n >= 11) ? 16'h1239 : 16'h1234;
      1:       stim = {b + 4'd3, b + 4'd2, b + 4'd1, b};
      2:       stim = 16'h5678;
      3:       stim = 16'h0050;
      default: stim = 16'h0000;
    endcase
  endfunction

  task automatic apply(input logic [15:0] v);
    {out_3, out_2, out_1, out_0} = v;
  endtask

  // Sample n is taken n cycles after the reset edge; cycle 1 is the first load
  task automatic check_dut(input int d, input int n, input logic [3:0] an_o,
                           input logic [6:0] seg_o, input logic ft_o);
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_ft;
    logic [15:0] snap;
    logic [3:0]  digit;
    logic        blank;
    int          idx;
    string       pfx;
    pfx = $sformatf("D%0d_n%0d", d, n);
    if (n <= 1) begin
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      exp_ft  = (n == 1);
    end else begin
      idx   = ((n - 2) / d) % 4;
      snap  = in_hist[1 + 4 * d * ((n - 2) / (4 * d))];
      digit = snap[idx*4 +: 4];
      blank = 1'b0;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      if (idx > 0) blank = ((snap >> (idx * 4)) == 16'h0000);
`endif
      exp_an  = an_tab[idx];
      exp_seg = blank ? 7'b1111111 : dec_tab[digit];
      exp_ft  = (((n - 1) % (4 * d)) == 0);
    end
    check_eq({pfx, "_an"}, {12'h000, an_o}, {12'h000, exp_an});
    check_eq({pfx, "_seg"}, {9'h000, seg_o}, {9'h000, exp_seg});
    check_eq({pfx, "_ft"}, {15'h0000, ft_o}, {15'h0000, exp_ft});
  endtask

  // One-cycle reset, then len sampled cycles driven from pattern mode
  task automatic run_phase(input int mode, input int len);
    logic [15:0] v;
    reset = 1'b1;
    @(negedge clk);
    check_dut(4, 0, an4, seg4, ft4);
    check_dut(2, 0, an2, seg2, ft2);
    reset = 1'b0;
    v = stim(mode, 1);
    in_hist[1] = v;
    apply(v);
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      check_dut(4, n, an4, seg4, ft4);
      check_dut(2, n, an2, seg2, ft2);
      v = stim(mode, n + 1);
      in_hist[n + 1] = v;
      apply(v);
    end
  endtask

  initial begin
    dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
    dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
    dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
    dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
    dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
    dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
    dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001;
    dec_tab[14] = 7'b0000110; dec_tab[15] = 7'b0001110;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    reset = 1'b1;
    apply(16'h0000);
    repeat (2) @(negedge clk);

    run_phase(0, 40);   // 1,2,3,4 scan; out_0 -> 9 mid-frame
    run_phase(0, 10);   // stops with digit 2 lit, then reset mid-frame
    run_phase(2, 20);   // fresh snapshot after the mid-frame reset
    run_phase(1, 260);  // out_0 sweeps 0..F across frames
    run_phase(3, 20);   // 0,0,5,0 leading-zero case
    run_phase(4, 20);   // all zeros

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
